shift_sequencer: RTL



---
 rtl/shift_seq_pkg.sv | 28 ++
 rtl/shift_stage_var.sv | 40 ++++
 rtl/shift_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the sequential right-shift controller.
package shift_seq_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ModeLogical = 2'd0,
        ModeArith   = 2'd1,
        ModeRotate  = 2'd2
    } mode_t;

    // Rotate takes priority over arithmetic fill.
    function automatic mode_t decode_mode(input logic rotate, input logic sra);
        if (rotate) begin
            return ModeRotate;
        end else if (sra) begin
            return ModeArith;
        end
        return ModeLogical;
    endfunction

endpackage

// File: rtl/shift_stage_var.sv
// Single reusable right-shift stage: shifts by 2^idx_i in the given mode when en_i is set.
module shift_stage_var
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_WIDTH,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned IDX_W   = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [IDX_W-1:0] idx_i,
    input  mode_t            mode_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    logic [SHAMT_W-1:0][WIDTH-1:0] cand;
    logic                          fill;

    assign fill = (mode_i == ModeArith) & data_i[WIDTH-1];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_dist
        localparam int unsigned Dist = 1 << k;
        assign cand[k] = (mode_i == ModeRotate) ?
                         {data_i[Dist-1:0], data_i[WIDTH-1:Dist]} :
                         {{Dist{fill}}, data_i[WIDTH-1:Dist]};
    end

    // Select the candidate for the current distance; pass through when disabled.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                if (idx_i == IDX_W'(k)) begin
                    data_o = cand[k];
                end
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit right shifter: one shared power-of-two stage applied per shamt bit,
// MSB first, between a request and a result valid/ready handshake.
// Optional macro SHIFT_SKIP_ZERO_EN: visit only set shamt bits (latency = popcount, min 1).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter  int unsigned WIDTH   = DATA_WIDTH,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_sra,
    input  logic               in_rotate,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam int unsigned IdxW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [IdxW-1:0]    idx_q, idx_d;

    logic [WIDTH-1:0]   stage_out;
    logic               stage_en;
    logic [IdxW-1:0]    first_idx;
    logic [IdxW-1:0]    next_idx;
    logic               last_step;

    shift_stage_var #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .IDX_W   (IdxW)
    ) u_stage (
        .data_i (acc_q),
        .idx_i  (idx_q),
        .mode_i (mode_q),
        .en_i   (stage_en),
        .data_o (stage_out)
    );

`ifdef SHIFT_SKIP_ZERO_EN
    // Highest set bit of the incoming shamt, and next lower set bit below idx_q.
    // shamt=0 starts at bit 0 with the stage disabled, giving a one-edge pass.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        last_step = 1'b1;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (in_shamt[k]) begin
                first_idx = IdxW'(k);
            end
            if (shamt_q[k] && (IdxW'(k) < idx_q)) begin
                next_idx  = IdxW'(k);
                last_step = 1'b0;
            end
        end
    end
`else
    // Fixed walk over every shamt bit from MSB down to bit 0.
    always_comb begin
        first_idx = IdxW'(SHAMT_W - 1);
        next_idx  = idx_q - 1'b1;
        last_step = (idx_q == '0);
    end
`endif

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        shamt_d   = shamt_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        stage_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    shamt_d = in_shamt;
                    mode_d  = decode_mode(in_rotate, in_sra);
                    idx_d   = first_idx;
                    state_d = StShift;
                end
            end
            StShift: begin
                stage_en = shamt_q[idx_q];
                acc_d    = stage_out;
                if (last_step) begin
                    state_d = StDone;
                end else begin
                    idx_d = next_idx;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            shamt_q <= '0;
            mode_q  <= ModeLogical;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
        end
    end

    assign out_data = acc_q;
    assign busy     = (state_q != StIdle);

endmodule
